// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared defaults and width helpers for the operand stack
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;
    localparam int SP_W        = $clog2(STACK_DEPTH + 1);

    // Stack pointer must represent 0..depth inclusive
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Entry address covers 0..depth-1; depth is at least 2 so this is never 0
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - controller-to-stack strobe and status bundle
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             tos_rd;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             tos_zero;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // Controller side drives strobes and push data
    modport master (
        output push, pop, tos_rd, err_clr, din,
        input  dout, tos_zero, empty, full, count, overflow, underflow
    );

    // Stack side consumes strobes and reports state
    modport slave (
        input  push, pop, tos_rd, err_clr, din,
        output dout, tos_zero, empty, full, count, overflow, underflow
    );

endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTHxWIDTH register file, sync write, async read
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack with registered top output and sticky errors
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);

    localparam int PW = sp_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    logic [PW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             is_empty, is_full;
    logic             do_swap, do_push, do_pop, do_rd;
    logic             ovf_evt, unf_evt;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == PW'(DEPTH));

    // Decode strobes against the pre-edge pointer; pop outranks tos_rd
    always_comb begin
        do_swap = bus.push && bus.pop && !is_empty;
        do_push = bus.push && !do_swap && !is_full;
        do_pop  = bus.pop && !is_empty;
        do_rd   = bus.tos_rd && !bus.pop && !is_empty;
        ovf_evt = bus.push && !do_swap && is_full;
        unf_evt = (bus.pop || bus.tos_rd) && is_empty;
    end

    // Swap overwrites the top slot; a plain push fills the next free slot
    always_comb begin
        ram_we    = do_push || do_swap;
        ram_waddr = do_swap ? AW'(sp_q - PW'(1)) : AW'(sp_q);
        ram_raddr = is_empty ? '0 : AW'(sp_q - PW'(1));
    end

    // Next-state for pointer, output register and sticky flags
    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        if (do_push) begin
            sp_d = sp_q + PW'(1);
        end else if (do_pop && !do_swap) begin
            sp_d = sp_q - PW'(1);
        end
        if (do_pop || do_rd) begin
            dout_d = ram_rdata;
        end
        ovf_d = (ovf_q && !bus.err_clr) || ovf_evt;
        unf_d = (unf_q && !bus.err_clr) || unf_evt;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.din),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.dout      = dout_q;
    assign bus.tos_zero  = (dout_q == '0);
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = sp_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed self-checking bench for stack_unit
module tb_stack_unit;

    localparam int W = 8;
    localparam int D = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    stack_unit_if #(.WIDTH(W), .DEPTH(D)) sif ();

    stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes, then sample 1 time unit after the edge
    task automatic cyc(input logic p, input logic q, input logic r, input logic c, input logic [7:0] d);
        sif.push    = p;
        sif.pop     = q;
        sif.tos_rd  = r;
        sif.err_clr = c;
        sif.din     = d;
        @(posedge clk);
        #1;
        sif.push    = 1'b0;
        sif.pop     = 1'b0;
        sif.tos_rd  = 1'b0;
        sif.err_clr = 1'b0;
    endtask

    task automatic push_v(input logic [7:0] d);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic pop_v();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        sif.push = 1'b0; sif.pop = 1'b0; sif.tos_rd = 1'b0; sif.err_clr = 1'b0; sif.din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(sif.count), 0);
        check("rst_empty", 32'(sif.empty), 1);
        check("rst_full", 32'(sif.full), 0);
        check("rst_dout", 32'(sif.dout), 0);
        check("rst_tz", 32'(sif.tos_zero), 1);
        check("rst_ovf", 32'(sif.overflow), 0);
        check("rst_unf", 32'(sif.underflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // LIFO order
        push_v(8'h05); push_v(8'h0A); push_v(8'h0F);
        check("lifo_count3", 32'(sif.count), 3);
        check("lifo_nempty", 32'(sif.empty), 0);
        pop_v(); check("lifo_pop1", 32'(sif.dout), 32'h0F);
        check("lifo_count2", 32'(sif.count), 2);
        pop_v(); check("lifo_pop2", 32'(sif.dout), 32'h0A);
        pop_v(); check("lifo_pop3", 32'(sif.dout), 32'h05);
        check("lifo_empty", 32'(sif.empty), 1);

        // Underflow keeps dout, sticky flag and clear behaviour
        pop_v();
        check("unf_dout", 32'(sif.dout), 32'h05);
        check("unf_flag", 32'(sif.underflow), 1);
        check("unf_count", 32'(sif.count), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("unf_clr", 32'(sif.underflow), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("unf_clr_new", 32'(sif.underflow), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("unf_tosrd_dout", 32'(sif.dout), 32'h05);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("unf_clr2", 32'(sif.underflow), 0);

        // Read without pop and zero flag
        push_v(8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("rd_dout0", 32'(sif.dout), 0);
        check("rd_tz1", 32'(sif.tos_zero), 1);
        check("rd_count1", 32'(sif.count), 1);
        push_v(8'h03);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("rd_dout3", 32'(sif.dout), 32'h03);
        check("rd_tz0", 32'(sif.tos_zero), 0);
        check("rd_count2", 32'(sif.count), 2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("poprd_dout", 32'(sif.dout), 32'h03);
        check("poprd_count", 32'(sif.count), 1);
        pop_v();
        check("rd_drain", 32'(sif.empty), 1);

        // Fill to overflow
        for (int i = 1; i <= D; i++) push_v(8'(i));
        check("fill_full", 32'(sif.full), 1);
        check("fill_count", 32'(sif.count), D);
        check("fill_novf", 32'(sif.overflow), 0);
        push_v(8'hFF);
        check("ovf_flag", 32'(sif.overflow), 1);
        check("ovf_count", 32'(sif.count), D);
        pop_v();
        check("ovf_pop", 32'(sif.dout), 16);
        check("ovf_nfull", 32'(sif.full), 0);
        for (int i = 1; i < D; i++) pop_v();
        check("ovf_last", 32'(sif.dout), 1);
        check("ovf_empty", 32'(sif.empty), 1);
        check("ovf_sticky", 32'(sif.overflow), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("ovf_clr", 32'(sif.overflow), 0);

        // Swap
        push_v(8'h07); push_v(8'h09);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        check("swap_dout", 32'(sif.dout), 32'h09);
        check("swap_count", 32'(sif.count), 2);
        pop_v(); check("swap_pop", 32'(sif.dout), 32'h22);
        pop_v(); check("swap_pop2", 32'(sif.dout), 32'h07);

        // Push+pop on empty acts as push and flags underflow
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
        check("pp_empty_count", 32'(sif.count), 1);
        check("pp_empty_unf", 32'(sif.underflow), 1);
        check("pp_empty_dout", 32'(sif.dout), 32'h07);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Push with tos_rd reads the old top
        push_v(8'h11);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
        check("ptr_dout", 32'(sif.dout), 32'h11);
        check("ptr_count", 32'(sif.count), 3);
        pop_v(); check("ptr_pop", 32'(sif.dout), 32'h33);
        pop_v(); pop_v();
        check("ptr_pop_last", 32'(sif.dout), 32'h44);
        check("ptr_empty", 32'(sif.empty), 1);

        // Asynchronous reset between edges
        push_v(8'h0A);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push_v(8'h01); push_v(8'h02);
        check("arst_pre_count", 32'(sif.count), 3);
        check("arst_pre_dout", 32'(sif.dout), 32'h0A);
        #1;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(sif.count), 0);
        check("arst_dout", 32'(sif.dout), 0);
        check("arst_tz", 32'(sif.tos_zero), 1);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
